lcu_col_ram_arb: RTL and testbench
==================================

LCU_COL_RAM_ARB -- requirements
Module: lcu_col_ram_arb

Interface
REQ-001 The block SHALL have these parameters: Word_Width, default 32, RAM word width; Addr_Width, default 6, RAM address width (64 words).
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  the single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req_i  in  1  writeback burst request.
- wr_addr_i  in  Addr_Width  burst start address.
- wr_len_i  in  Addr_Width  burst word count minus 1.
- wr_data_i  in  Word_Width  write word; sampled in every cycle wr_ack_o=1.
- wr_ack_o  out  1  write word accepted this cycle.
- wr_done_o  out  1  pulse on the last write word.
- rd_req_i  in  1  reference-fetch burst request.
- rd_addr_i  in  Addr_Width  burst start address.
- rd_len_i  in  Addr_Width  burst word count minus 1.
- rd_ack_o  out  1  read word issued to the RAM this cycle.
- rd_valid_o  out  1  read data valid.
- rd_data_o  out  Word_Width  read data.
- rd_done_o  out  1  pulse with the last rd_valid_o.
- ram_cen_o  out  1  RAM chip enable, active low.
- ram_oen_o  out  1  RAM output enable, active low.
- ram_wen_o  out  1  RAM write enable, active low; 1 means read.
- ram_addr_o  out  Addr_Width  RAM address.
- ram_data_o  out  Word_Width  RAM write data.
- ram_data_i  in  Word_Width  RAM read data; valid one cycle after a read is issued.
- busy_o  out  1  FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have exactly three states, IDLE, WR and RD, and SHALL reset to IDLE.
REQ-004 In IDLE with exactly one request asserted, the FSM SHALL enter that requester's state on the next edge.
REQ-005 In IDLE with both requests asserted, the winner SHALL be the requester that did not win the last grant (round-robin).
REQ-006 The round-robin pointer SHALL reset to favour write.
REQ-007 On leaving IDLE, the block SHALL latch the winner's start address and length into an address counter and a word counter.
REQ-008 In WR, every cycle SHALL drive ram_cen_o=0, ram_wen_o=0, ram_addr_o=counter, ram_data_o=wr_data_i and wr_ack_o=1.
REQ-009 In RD, every cycle SHALL drive ram_cen_o=0, ram_wen_o=1, ram_addr_o=counter and rd_ack_o=1.
REQ-010 The address counter SHALL increment by 1 per word and wrap modulo 2^Addr_Width (63 to 0).
REQ-011 A burst SHALL transfer exactly len+1 words; len=63 SHALL access all 64 words once.
REQ-012 wr_done_o SHALL be asserted in the same cycle as the last wr_ack_o.
REQ-013 After the last word of a burst, the FSM SHALL return to IDLE, giving one arbitration bubble cycle between bursts.
REQ-014 Deassertion of a request mid-burst SHALL be ignored; the burst runs to completion.
REQ-015 Changes to a requester's addr/len inputs mid-burst SHALL have no effect.
REQ-016 rd_valid_o SHALL be rd_ack_o registered by one cycle.
REQ-017 rd_data_o SHALL equal ram_data_i when rd_valid_o=1, and 0 otherwise.
REQ-018 ram_oen_o SHALL equal the inverse of rd_valid_o.
REQ-019 rd_done_o SHALL be asserted with the rd_valid_o of the last word.
REQ-020 Read latency SHALL be: request seen in IDLE at cycle T, first rd_ack_o at T+1, first rd_valid_o at T+2.
REQ-021 In IDLE and in any cycle without access, the RAM outputs SHALL be ram_cen_o=1, ram_wen_o=1, ram_addr_o=0 and ram_data_o=0.
REQ-022 wr_ack_o and rd_ack_o SHALL never be asserted in the same cycle.
REQ-023 busy_o SHALL be 1 in the WR and RD states.
REQ-024 A request arriving while the FSM is not in IDLE SHALL wait without loss until the next IDLE cycle.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately force the FSM to IDLE, counters to 0, round-robin pointer to write-first, and all outputs to their inactive values (enables 1, others 0), without waiting for a clock edge.
REQ-026 A reset asserted mid-burst SHALL abort the burst with no done pulse; the trailing rd_valid_o SHALL be cleared.
REQ-027 After rst_n is released, the block SHALL accept requests on the first following edge.

Verification
REQ-028 Write wr_addr_i=10, wr_len_i=3, data 0xA0..0xA3 -> wr_ack_o high 4 cycles, addresses 10..13, wr_done_o on the 4th cycle.
REQ-029 Read rd_addr_i=62, rd_len_i=3 after the memory is prefilled -> addresses 62,63,0,1, data valid at T+2..T+5, rd_done_o at T+5.
REQ-030 Both requests held continuously with len=0 from reset -> grants alternate W,R,W,R with one IDLE cycle between each.
REQ-031 rd_req_i dropped after 1 cycle of a len=7 burst -> all 8 reads are issued and rd_done_o fires.
REQ-032 rst_n pulsed low during the 3rd word of a len=5 write -> outputs go inactive at once, no wr_done_o, the next request is granted write-first.
REQ-033 wr_len_i=63 -> 64 writes, addresses wrap from 63 to 0 back to the start address, then read back with rd_len_i=63 matches bit-exactly.

Source files
------------

// File: rtl/lcu_col_ram_arb.sv
// Round-robin arbiter sharing one single-port column RAM between a writeback
// burst port and a reference-fetch burst port.
module lcu_col_ram_arb #(
    parameter int unsigned Word_Width = 32,
    parameter int unsigned Addr_Width = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req_i,
    input  logic [Addr_Width-1:0] wr_addr_i,
    input  logic [Addr_Width-1:0] wr_len_i,
    input  logic [Word_Width-1:0] wr_data_i,
    output logic                  wr_ack_o,
    output logic                  wr_done_o,
    input  logic                  rd_req_i,
    input  logic [Addr_Width-1:0] rd_addr_i,
    input  logic [Addr_Width-1:0] rd_len_i,
    output logic                  rd_ack_o,
    output logic                  rd_valid_o,
    output logic [Word_Width-1:0] rd_data_o,
    output logic                  rd_done_o,
    output logic                  ram_cen_o,
    output logic                  ram_oen_o,
    output logic                  ram_wen_o,
    output logic [Addr_Width-1:0] ram_addr_o,
    output logic [Word_Width-1:0] ram_data_o,
    input  logic [Word_Width-1:0] ram_data_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    state_e                state_q, state_d;
    logic [Addr_Width-1:0] addr_q, addr_d;
    logic [Addr_Width-1:0] cnt_q, cnt_d;
    logic                  prio_wr_q, prio_wr_d;
    logic                  rd_valid_q, rd_last_q;
    logic                  last_word;

    assign last_word = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cnt_q      <= '0;
            prio_wr_q  <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            prio_wr_q  <= prio_wr_d;
            rd_valid_q <= (state_q == StRd);
            rd_last_q  <= (state_q == StRd) && last_word;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        prio_wr_d = prio_wr_q;
        unique case (state_q)
            StIdle: begin
                // prio_wr_q holds the loser of the previous grant
                if (wr_req_i && (!rd_req_i || prio_wr_q)) begin
                    state_d   = StWr;
                    addr_d    = wr_addr_i;
                    cnt_d     = wr_len_i;
                    prio_wr_d = 1'b0;
                end else if (rd_req_i) begin
                    state_d   = StRd;
                    addr_d    = rd_addr_i;
                    cnt_d     = rd_len_i;
                    prio_wr_d = 1'b1;
                end
            end
            StWr, StRd: begin
                addr_d = addr_q + Addr_Width'(1);
                cnt_d  = cnt_q - Addr_Width'(1);
                if (last_word) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ack_o   = (state_q == StWr);
        rd_ack_o   = (state_q == StRd);
        wr_done_o  = wr_ack_o && last_word;
        busy_o     = (state_q != StIdle);
        ram_cen_o  = !(wr_ack_o || rd_ack_o);
        ram_wen_o  = !wr_ack_o;
        ram_addr_o = (wr_ack_o || rd_ack_o) ? addr_q : '0;
        ram_data_o = wr_ack_o ? wr_data_i : '0;
        rd_valid_o = rd_valid_q;
        rd_done_o  = rd_last_q;
        rd_data_o  = rd_valid_q ? ram_data_i : '0;
        ram_oen_o  = !rd_valid_q;
    end

endmodule

// File: tb/tb_lcu_col_ram_arb.sv
// Scoreboard bench for lcu_col_ram_arb: directed bursts push expected RAM
// accesses into queues; a negedge monitor pops and compares them.
module tb_lcu_col_ram_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req_i = 1'b0;
    logic [5:0]  wr_addr_i = '0;
    logic [5:0]  wr_len_i = '0;
    logic [31:0] wr_data_i;
    logic        wr_ack_o, wr_done_o;
    logic        rd_req_i = 1'b0;
    logic [5:0]  rd_addr_i = '0;
    logic [5:0]  rd_len_i = '0;
    logic        rd_ack_o, rd_valid_o, rd_done_o;
    logic [31:0] rd_data_o;
    logic        ram_cen_o, ram_oen_o, ram_wen_o;
    logic [5:0]  ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i = '0;
    logic        busy_o;

    lcu_col_ram_arb #(.Word_Width(32), .Addr_Width(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_len_i(wr_len_i),
        .wr_data_i(wr_data_i), .wr_ack_o(wr_ack_o), .wr_done_o(wr_done_o),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_len_i(rd_len_i),
        .rd_ack_o(rd_ack_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .rd_done_o(rd_done_o), .ram_cen_o(ram_cen_o), .ram_oen_o(ram_oen_o),
        .ram_wen_o(ram_wen_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_data_i(ram_data_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write data source: consecutive words, advanced on every accepted word
    logic [31:0] wr_seq = '0;
    logic [31:0] wr_base = '0;
    assign wr_data_i = wr_base + wr_seq;
    always @(posedge clk) if (wr_ack_o) wr_seq <= wr_seq + 1;

    // Synchronous RAM model: read data one cycle after the read is issued
    logic [31:0] mem [64];
    logic [31:0] exp_mem [64];
    always @(posedge clk) begin
        if (!ram_cen_o && !ram_wen_o) mem[ram_addr_o] <= ram_data_o;
        ram_data_i <= (!ram_cen_o && ram_wen_o) ? mem[ram_addr_o] : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic        done;
        int          cyc;
    } ent_t;

    ent_t wq[$];
    ent_t raq[$];
    ent_t rvq[$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_wr(input int a, input int l, input logic [31:0] d0,
                                    input int c0, input int n);
        ent_t e;
        for (int k = 0; k < n; k++) begin
            e.addr = 6'((a + k) % 64);
            e.data = d0 + 32'(k);
            e.done = (k == l);
            e.cyc  = c0 + k;
            exp_mem[e.addr] = e.data;
            wq.push_back(e);
        end
    endfunction

    function automatic void push_rd(input int a, input int l, input int c0);
        ent_t e;
        for (int k = 0; k <= l; k++) begin
            e.addr = 6'((a + k) % 64);
            e.data = exp_mem[e.addr];
            e.done = (k == l);
            e.cyc  = c0 + k;
            raq.push_back(e);
            e.cyc  = c0 + k + 1;
            rvq.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        ent_t e;
        if (rst_n) begin
            chk("ack_exclusive", 32'(wr_ack_o & rd_ack_o), 0);
            if (wr_ack_o) begin
                if (wq.size() == 0) chk("wr_unexpected", 32'(wr_ack_o), 0);
                else begin
                    e = wq.pop_front();
                    chk("wr_addr", 32'(ram_addr_o), 32'(e.addr));
                    chk("wr_data", ram_data_o, e.data);
                    chk("wr_done", 32'(wr_done_o), 32'(e.done));
                    chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                    chk("wr_cen_wen", {30'd0, ram_cen_o, ram_wen_o}, 0);
                end
            end else begin
                chk("wr_done_idle", 32'(wr_done_o), 0);
            end
            if (rd_ack_o) begin
                if (raq.size() == 0) chk("rd_unexpected", 32'(rd_ack_o), 0);
                else begin
                    e = raq.pop_front();
                    chk("rd_addr", 32'(ram_addr_o), 32'(e.addr));
                    chk("rd_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rd_cen_wen", {30'd0, ram_cen_o, ram_wen_o}, 1);
                end
            end
            if (rd_valid_o) begin
                if (rvq.size() == 0) chk("rv_unexpected", 32'(rd_valid_o), 0);
                else begin
                    e = rvq.pop_front();
                    chk("rd_data", rd_data_o, e.data);
                    chk("rd_done", 32'(rd_done_o), 32'(e.done));
                    chk("rv_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rd_oen", 32'(ram_oen_o), 0);
                end
            end else begin
                chk("rd_idle", {rd_data_o[30:0], rd_done_o}, 0);
                chk("oen_idle", 32'(ram_oen_o), 1);
            end
            if (!wr_ack_o && !rd_ack_o) begin
                chk("ram_idle", {ram_data_o[29:0], ram_cen_o, ram_wen_o}, 3);
                chk("ram_addr_idle", 32'(ram_addr_o), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy_o), 0);
        tick();
        tick();
    endtask

    task automatic do_wr(input int a, input int l, input logic [31:0] d0);
        wr_base = d0 - wr_seq;
        push_wr(a, l, d0, cyc + 1, l + 1);
        wr_req_i  = 1'b1;
        wr_addr_i = 6'(a);
        wr_len_i  = 6'(l);
        tick();
        chk("busy_wr", 32'(busy_o), 1);
        // Request and burst parameters change mid-burst; must be ignored
        wr_req_i  = 1'b0;
        wr_addr_i = ~6'(a);
        wr_len_i  = 6'd0;
        wait_idle();
    endtask

    task automatic do_rd(input int a, input int l);
        push_rd(a, l, cyc + 1);
        rd_req_i  = 1'b1;
        rd_addr_i = 6'(a);
        rd_len_i  = 6'(l);
        tick();
        chk("busy_rd", 32'(busy_o), 1);
        rd_req_i  = 1'b0;
        rd_addr_i = ~6'(a);
        rd_len_i  = 6'd1;
        wait_idle();
    endtask

    task automatic check_inactive(input string tag);
        chk({tag, "_acks"}, {28'd0, wr_ack_o, wr_done_o, rd_ack_o, rd_valid_o}, 0);
        chk({tag, "_enables"}, {29'd0, ram_cen_o, ram_oen_o, ram_wen_o}, 7);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_addr"}, 32'(ram_addr_o), 0);
        chk({tag, "_data"}, ram_data_o | rd_data_o, 0);
        chk({tag, "_rd_done"}, 32'(rd_done_o), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h0C0C_0000 + 32'(i);
            exp_mem[i] = 32'h0C0C_0000 + 32'(i);
        end
        #12;
        check_inactive("reset");
        tick();
        rst_n = 1'b1;

        // Both requests held from reset, len=0: W,R,W,R with bubbles
        n = cyc;
        wr_base = 32'hB0 - wr_seq;
        push_wr(5, 0, 32'hB0, n + 1, 1);
        push_rd(33, 0, n + 3);
        push_wr(5, 0, 32'hB1, n + 5, 1);
        push_rd(33, 0, n + 7);
        wr_req_i = 1'b1; wr_addr_i = 6'd5; wr_len_i = 6'd0;
        rd_req_i = 1'b1; rd_addr_i = 6'd33; rd_len_i = 6'd0;
        repeat (7) tick();
        wr_req_i = 1'b0;
        rd_req_i = 1'b0;
        wait_idle();

        do_wr(10, 3, 32'hA0);
        do_wr(60, 7, 32'h100);
        do_rd(62, 3);
        do_rd(60, 7);

        // Reset during the third word of a len=5 write
        wr_base = 32'hD0 - wr_seq;
        n = cyc;
        push_wr(40, 5, 32'hD0, n + 1, 2);
        wr_req_i = 1'b1; wr_addr_i = 6'd40; wr_len_i = 6'd5;
        tick();
        wr_req_i = 1'b0;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1 check_inactive("abort");
        tick();
        // Last grant was a write, but reset restores write-first priority
        rst_n = 1'b1;
        n = cyc;
        wr_base = 32'hC0 - wr_seq;
        push_wr(20, 0, 32'hC0, n + 1, 1);
        push_rd(0, 0, n + 3);
        wr_req_i = 1'b1; wr_addr_i = 6'd20; wr_len_i = 6'd0;
        rd_req_i = 1'b1; rd_addr_i = 6'd0; rd_len_i = 6'd0;
        tick();
        wr_req_i = 1'b0;
        tick();
        tick();
        rd_req_i = 1'b0;
        wait_idle();

        do_wr(7, 63, 32'h5000);
        do_rd(7, 63);

        chk("wq_drained", 32'(wq.size()), 0);
        chk("raq_drained", 32'(raq.size()), 0);
        chk("rvq_drained", 32'(rvq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
